// File: rtl/image_buffer_pkg.sv
// Shared definitions for the image byte buffer: FIFO entry tag layout,
// image type codes and FSM state encodings.
package image_buffer_pkg;

  // Tag bit offsets above the DATA_W data field of a FIFO entry.
  localparam int TYPE_BIT = 0;
  localparam int EOF_BIT  = 1;
  localparam int SOF_BIT  = 2;
  localparam int TAG_W    = 3;

  localparam logic IMG_NAV = 1'b0;
  localparam logic IMG_SCI = 1'b1;

  typedef enum logic {
    IN_IDLE,
    IN_IMG
  } in_state_e;

  typedef enum logic {
    TRK_IDLE,
    TRK_ACTIVE
  } trk_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head entry is always
// visible on rd_data while !empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when indices match.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/image_byte_buffer.sv
// Tagged image FIFO between the JPEG block and the flash SPI writer; frames
// incoming words and reports size/index/type once an image fully drains.
module image_byte_buffer
  import image_buffer_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int SIZE_W  = 32,
  parameter int INDEX_W = 16
) (
  input  logic                     sysClk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic                     in_eof,
  input  logic                     in_image_type,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     navigation_image_added_flag,
  output logic                     science_image_added_flag,
  output logic [SIZE_W-1:0]        image_size,
  output logic                     image_size_output_valid,
  output logic [INDEX_W-1:0]       image_index,
  output logic                     image_index_output_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     protocol_error
);

  localparam int EW = DATA_W + TAG_W;

  logic          full, empty, accept, drain;
  logic [EW-1:0] wr_entry, head;
  logic          head_sof, head_eof, head_type;

  // Input framing
  in_state_e     in_st, in_st_nxt;
  logic          in_type_q, in_type_nxt, wr_en, wr_type, perr_nxt;

  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  assign wr_entry = {in_sof, in_eof, wr_type, in_data};

  always_comb begin
    in_st_nxt   = in_st;
    in_type_nxt = in_type_q;
    wr_en       = 1'b0;
    wr_type     = in_type_q;
    perr_nxt    = 1'b0;
    if (accept) begin
      case (in_st)
        IN_IDLE: begin
          if (in_sof) begin
            wr_en       = 1'b1;
            wr_type     = in_image_type;
            in_type_nxt = in_image_type;
            in_st_nxt   = in_eof ? IN_IDLE : IN_IMG;
          end else begin
            perr_nxt = 1'b1;
          end
        end
        IN_IMG: begin
          wr_en = 1'b1;
          // A restart mid-image is flagged but still becomes a new image.
          if (in_sof) begin
            perr_nxt    = 1'b1;
            wr_type     = in_image_type;
            in_type_nxt = in_image_type;
          end
          in_st_nxt = in_eof ? IN_IDLE : IN_IMG;
        end
        default: in_st_nxt = IN_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sysClk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .full    (full),
    .rd_en   (drain),
    .rd_data (head),
    .empty   (empty),
    .count   (fill_level)
  );

  assign out_valid = !empty;
  assign drain     = out_valid && out_ready;
  assign out_data  = empty ? '0 : head[DATA_W-1:0];
  assign head_sof  = head[DATA_W+SOF_BIT];
  assign head_eof  = head[DATA_W+EOF_BIT];
  assign head_type = head[DATA_W+TYPE_BIT];

  // Output tracking
  trk_state_e        trk_st, trk_nxt;
  logic [SIZE_W-1:0] cnt_q, cnt_nxt;
  logic              typ_q, typ_nxt, done, done_q, done_type;
  logic [INDEX_W-1:0] idx_q;

  always_comb begin
    trk_nxt = trk_st;
    cnt_nxt = cnt_q;
    typ_nxt = typ_q;
    done    = 1'b0;
    if (drain) begin
      if (head_sof) begin
        cnt_nxt = SIZE_W'(1);
        typ_nxt = head_type;
        trk_nxt = TRK_ACTIVE;
      end else if (trk_st == TRK_ACTIVE) begin
        cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
      if (head_eof && (head_sof || trk_st == TRK_ACTIVE)) begin
        done    = 1'b1;
        trk_nxt = TRK_IDLE;
      end
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      in_st          <= IN_IDLE;
      in_type_q      <= IMG_NAV;
      protocol_error <= 1'b0;
      trk_st         <= TRK_IDLE;
      cnt_q          <= '0;
      typ_q          <= IMG_NAV;
      done_q         <= 1'b0;
      done_type      <= IMG_NAV;
      idx_q          <= '0;
      image_size     <= '0;
      image_index    <= '0;
    end else begin
      in_st          <= in_st_nxt;
      in_type_q      <= in_type_nxt;
      protocol_error <= perr_nxt;
      trk_st         <= trk_nxt;
      cnt_q          <= cnt_nxt;
      typ_q          <= typ_nxt;
      done_q         <= done;
      // Report registers load on the eof drain so the pulse lands one cycle later.
      if (done) begin
        image_size  <= cnt_nxt;
        image_index <= idx_q;
        done_type   <= typ_nxt;
        idx_q       <= idx_q + 1'b1;
      end
    end
  end

  assign image_size_output_valid     = done_q;
  assign image_index_output_valid    = done_q;
  assign navigation_image_added_flag = done_q && (done_type == IMG_NAV);
  assign science_image_added_flag    = done_q && (done_type == IMG_SCI);

endmodule

// File: tb/tb_image_byte_buffer.sv
// Scoreboard bench for image_byte_buffer: stimulus queues expected words and
// completions, a negedge monitor pops and compares as the DUT presents them.
module tb_image_byte_buffer;
  localparam int DATA_W = 8, DEPTH = 8, SIZE_W = 32, INDEX_W = 2;
  localparam int FL_W = $clog2(DEPTH) + 1;

  logic              sysClk = 1'b0, rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_image_type = 1'b0;
  logic              in_ready, out_valid, out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              nav_flag, sci_flag, size_vld, idx_vld, protocol_error;
  logic [SIZE_W-1:0] image_size;
  logic [INDEX_W-1:0] image_index;
  logic [FL_W-1:0]   fill_level;

  image_byte_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SIZE_W(SIZE_W), .INDEX_W(INDEX_W)) dut (
    .sysClk(sysClk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_eof(in_eof), .in_image_type(in_image_type),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .navigation_image_added_flag(nav_flag), .science_image_added_flag(sci_flag),
    .image_size(image_size), .image_size_output_valid(size_vld),
    .image_index(image_index), .image_index_output_valid(idx_vld),
    .fill_level(fill_level), .protocol_error(protocol_error));

  always #5 sysClk = ~sysClk;

  typedef struct { logic [DATA_W-1:0] d; logic eof; } word_t;
  typedef struct { int size; int idx; logic typ; } done_t;

  word_t wq[$];
  done_t dq[$];
  int errors = 0, checks = 0;
  int pe_seen = 0, done_seen = 0, exp_idx = 0, exp_pe = 0;
  logic eof_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge sysClk) begin
    if (rst) begin
      eof_prev = 1'b0;
    end else begin
      if (size_vld || eof_prev) chk("pulse_latency", 64'(size_vld), 64'(eof_prev));
      if (size_vld) begin
        done_t e;
        done_seen++;
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got size %0d expected none", image_size);
        end else begin
          e = dq.pop_front();
          chk("image_size", 64'(image_size), 64'(e.size));
          chk("image_index", 64'(image_index), 64'(e.idx));
          chk("index_valid", 64'(idx_vld), 64'd1);
          chk("nav_flag", 64'(nav_flag), 64'(!e.typ));
          chk("sci_flag", 64'(sci_flag), 64'(e.typ));
        end
      end else if (nav_flag || sci_flag || idx_vld) begin
        chk("stray_flag", 64'({nav_flag, sci_flag, idx_vld}), 64'd0);
      end
      if (protocol_error) pe_seen++;
      eof_prev = 1'b0;
      if (out_valid && out_ready) begin
        word_t w;
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          w = wq.pop_front();
          chk("out_data", 64'(out_data), 64'(w.d));
          eof_prev = w.eof;
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic sof, input logic eof,
                      input logic typ, input bit kept);
    int t = 0;
    in_data = d; in_sof = sof; in_eof = eof; in_image_type = typ; in_valid = 1'b1;
    if (kept) wq.push_back('{d, eof});
    while (!in_ready && t < 2000) begin @(posedge sysClk); #1; t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge sysClk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic expect_done(input int size, input logic typ);
    dq.push_back('{size, exp_idx, typ});
    exp_idx = (exp_idx + 1) % (1 << INDEX_W);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < 1000) begin @(posedge sysClk); t++; end
    if (wq.size() != 0 || dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", wq.size() + dq.size());
    end
    repeat (2) @(posedge sysClk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wq.delete(); dq.delete(); exp_idx = 0;
    @(posedge sysClk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_flags", 64'({nav_flag, sci_flag, size_vld, idx_vld, protocol_error}), 64'd0);
    @(posedge sysClk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pe_base, done_base;
    do_reset();

    // 5-word navigation image streamed through
    out_ready = 1'b1;
    expect_done(5, 1'b0);
    send(8'h11, 1, 0, 0, 1);
    send(8'h12, 0, 0, 0, 1);
    send(8'h13, 0, 0, 0, 1);
    chk("fill_steady", 64'(fill_level), 64'd1);
    send(8'h14, 0, 0, 0, 1);
    send(8'h15, 0, 1, 0, 1);
    wait_idle();

    // Fill to DEPTH under backpressure, then drain DEPTH+3 words
    out_ready = 1'b0;
    expect_done(DEPTH + 3, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i), i == 0, 0, 0, 1);
    chk("full_fill", 64'(fill_level), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(8'h30 + i), 0, i == 2, 0, 1);
    wait_idle();
    chk("empty_fill", 64'(fill_level), 64'd0);

    // Single-word science image, then next image reports index 1
    do_reset();
    out_ready = 1'b1;
    expect_done(1, 1'b1);
    send(8'hA5, 1, 1, 1, 1);
    expect_done(2, 1'b0);
    send(8'hB0, 1, 0, 0, 1);
    send(8'hB1, 0, 1, 0, 1);
    wait_idle();

    // Framing errors: stray word in IDLE, restart after 3 words
    pe_base = pe_seen;
    send(8'h40, 0, 0, 0, 0);
    send(8'h41, 1, 0, 0, 1);
    send(8'h42, 0, 0, 0, 1);
    send(8'h43, 0, 0, 0, 1);
    expect_done(4, 1'b1);
    send(8'h50, 1, 0, 1, 1);
    send(8'h51, 0, 0, 1, 1);
    send(8'h52, 0, 0, 1, 1);
    send(8'h53, 0, 1, 1, 1);
    wait_idle();
    chk("protocol_errors", 64'(pe_seen - pe_base), 64'd2);
    exp_pe += 2;

    // Reset mid-image discards buffered words
    out_ready = 1'b0;
    done_base = done_seen;
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), i == 0, 0, 0, 1);
    repeat (2) @(posedge sysClk); #1;
    chk("no_flags_before_rst", 64'(done_seen - done_base), 64'd0);
    do_reset();
    out_ready = 1'b1;
    expect_done(2, 1'b0);
    send(8'h70, 1, 0, 0, 1);
    send(8'h71, 0, 1, 0, 1);
    wait_idle();

    // Index wrap with back-to-back completions
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_done(1, 1'(i % 2));
      send(8'(8'h80 + i), 1, 1, 1'(i % 2), 1);
    end
    out_ready = 1'b1;
    wait_idle();
    chk("total_protocol_errors", 64'(pe_seen), 64'(exp_pe));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_byte_buffer.md
Name: image_byte_buffer

Overview:
- Parametrised successor to the single-stream JPEG byte buffer.
- Sits between the JPEG block output and the flash-memory SPI writer.
- Buffers DEPTH data words with ready/valid backpressure on both sides and carries start/end-of-image tags through the FIFO.
- Reports per-image size, a running image index and navigation/science "image added" pulses when an image's last byte has actually left toward flash.

Parameters:
DATA_W, 8, width of one data word
DEPTH, 64, FIFO entries; must be a power of two, at least 4
SIZE_W, 32, width of the image byte counter and image_size
INDEX_W, 16, width of image_index

Ports:
sysClk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_data  in  DATA_W  word from JPEG block
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept a word
in_sof  in  1  word is first of an image (qualified by in_valid)
in_eof  in  1  word is last of an image (qualified by in_valid)
in_image_type  in  1  0 = navigation, 1 = science; sampled with in_sof
out_data  out  DATA_W  word for flash SPI
out_valid  out  1  out_data valid
out_ready  in  1  SPI side accepts word
navigation_image_added_flag  out  1  1-cycle pulse: navigation image fully drained
science_image_added_flag  out  1  1-cycle pulse: science image fully drained
image_size  out  SIZE_W  word count of the completed image
image_size_output_valid  out  1  1-cycle pulse qualifying image_size
image_index  out  INDEX_W  index of the completed image
image_index_output_valid  out  1  1-cycle pulse qualifying image_index
fill_level  out  clog2(DEPTH)+1  entries currently held
protocol_error  out  1  1-cycle pulse on input framing violation

Behaviour:
- Reset, asynchronous, all outputs low or zero:
  - FIFO empty; in_ready=0 while rst is high, 1 on the first cycle after release.
  - Both FSMs go to IDLE; image index counter = 0.
- Reset mid-image discards all buffered data and partial counts; no flags fire.
- FIFO entry = {sof, eof, type, data}.
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !full. out_valid = !empty.
- out_data is first-word-fall-through from the head entry.
- Write-to-out_valid latency: 1 cycle.
- Simultaneous accept and drain:
  - When not full, fill_level is unchanged.
  - When full, in_ready=0, so only the drain occurs.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- Input FSM:
  - IDLE:
    - Accepted word with in_sof: write it with the type latched, then go to IN_IMG.
    - If in_eof is also set: single-word image, stay IDLE.
    - Accepted word without in_sof: dropped (not written), protocol_error pulse.
  - IN_IMG:
    - Accepted words are written with the latched type.
    - in_eof: go to IDLE.
    - in_sof: protocol_error pulse; the word is written as the start of a new image with the new type.
- Output tracker FSM, driven on drain only:
  - Draining a sof entry: cnt=1, type latched, go to ACTIVE.
  - In ACTIVE, each drained word: cnt+1, saturating at 2^SIZE_W-1.
  - Draining an eof entry sets image_size=cnt including that word, then on the next cycle:
    - Both valid strobes high with image_index = current index.
    - The type flag pulses.
    - The index increments, wrapping 2^INDEX_W-1 to 0.
    - The FSM goes to IDLE.
  - A sof entry drained while ACTIVE (aborted image): the old count is discarded, no flags, restart at cnt=1.
  - Non-sof drains in IDLE cannot occur by construction.
- image_size and image_index hold their last value between pulses.
- Pulse latency: exactly 1 cycle after the eof drain cycle.
- Back-to-back eof drains produce back-to-back pulses.

Decomposition:
- Package image_buffer_pkg:
  - entry field offsets (SOF_BIT, EOF_BIT, TYPE_BIT);
  - IMG_NAV/IMG_SCI constants;
  - FSM state encodings.
- One sub-module sync_fifo_fwft:
  - parameters WIDTH, DEPTH;
  - ports wr_en, wr_data, full, rd_en, rd_data, empty, count.
- Framing and tracking logic stays in the top module.

Test Plan:
- Navigation image of 5 words, out_ready=1 → out_data order preserved; one cycle after the 5th drain, image_size=5, image_index=0, navigation flag pulses, science flag stays 0.
- out_ready=0 while writing DEPTH+3 words → in_ready drops after DEPTH accepts, fill_level=DEPTH; raising out_ready drains all words with no loss or duplication.
- Single word with sof and eof, type=1 → image_size=1, science flag pulses; next image reports index 1.
- Word without sof in IDLE, then sof while IN_IMG after 3 words, then 4 words ending in eof → two protocol_error pulses; exactly one completion with size 4.
- Assert rst midway through a 10-word image, then send a fresh 2-word image → no flags before rst; after it, size=2, index=0.
- Preload image_index to 2^INDEX_W-1 via 2^INDEX_W completions (INDEX_W=2 build) → the fifth image reports index 0.
